// File: rtl/irq_prio_ctrl.sv
// Registered priority interrupt controller: NUM_GRP groups of GRP_W channels, mask, req/ack handshake.
// Define IRQ_EDGE_CAPTURE_EN for sticky rising-edge capture with a saturating lost-edge counter.
module irq_prio_ctrl #(
  parameter int NUM_GRP = 3,
  parameter int GRP_W   = 9,
  parameter int CH_W    = $clog2(GRP_W),
  parameter int ID_W    = $clog2(NUM_GRP*GRP_W),
  parameter int CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_GRP*GRP_W-1:0]   req,
  input  logic                       mask_we,
  input  logic [NUM_GRP*GRP_W-1:0]   mask_wdata,
  output logic [NUM_GRP*GRP_W-1:0]   mask,
  output logic                       irq_valid,
  output logic [NUM_GRP-1:0]         irq_grp,
  output logic [CH_W-1:0]            irq_ch,
  output logic [ID_W-1:0]            irq_id,
  input  logic                       irq_ack,
  output logic                       any_pending,
  output logic [CNT_W-1:0]           drop_cnt
);
  localparam int N = NUM_GRP * GRP_W;

  typedef enum logic [1:0] {IDLE, ARB, GRANT} state_t;

  state_t              state_reg, state_next;
  logic [N-1:0]        req_q_reg;
  logic [N-1:0]        mask_reg;
  logic [N-1:0]        src;
  logic [N-1:0]        elig;
  logic                any_pending_reg;
  logic                irq_valid_reg, irq_valid_next;
  logic [NUM_GRP-1:0]  irq_grp_reg, irq_grp_next;
  logic [CH_W-1:0]     irq_ch_reg, irq_ch_next;
  logic [ID_W-1:0]     irq_id_reg, irq_id_next;
  logic                ack_fire;

  logic [NUM_GRP-1:0]      grp_hit;
  logic [NUM_GRP*CH_W-1:0] grp_ch_flat;
  logic [NUM_GRP-1:0]      win_grp;
  logic [CH_W-1:0]         win_ch;
  logic [ID_W-1:0]         win_id;

  assign elig     = src & ~mask_reg;
  assign ack_fire = (state_reg == GRANT) && irq_ack;

  // Per-group lowest-index channel search, then lowest group wins below.
  for (genvar gi = 0; gi < NUM_GRP; gi++) begin : g_grp
    logic [CH_W-1:0] ch_sel;
    assign grp_hit[gi] = |elig[gi*GRP_W +: GRP_W];
    always_comb begin
      ch_sel = '0;
      for (int c = GRP_W - 1; c >= 0; c--) begin
        if (elig[gi*GRP_W + c]) ch_sel = CH_W'(c);
      end
    end
    assign grp_ch_flat[gi*CH_W +: CH_W] = ch_sel;
  end

  always_comb begin
    win_grp = '0;
    win_ch  = '0;
    win_id  = '0;
    for (int g = NUM_GRP - 1; g >= 0; g--) begin
      if (grp_hit[g]) begin
        win_grp    = '0;
        win_grp[g] = 1'b1;
        win_ch     = grp_ch_flat[g*CH_W +: CH_W];
        win_id     = ID_W'(g * GRP_W) + ID_W'(grp_ch_flat[g*CH_W +: CH_W]);
      end
    end
  end

`ifdef IRQ_EDGE_CAPTURE_EN
  logic [N-1:0]     pend_reg, pend_next, rise, clr;
  logic             drop_evt;
  logic [CNT_W-1:0] drop_cnt_reg;

  assign rise = req & ~req_q_reg;

  always_comb begin
    clr = '0;
    for (int i = 0; i < N; i++) begin
      clr[i] = ack_fire && (irq_id_reg == ID_W'(i));
    end
  end

  // A bit being cleared by ack while a new edge arrives keeps the new edge, so it is not a drop.
  assign pend_next = (pend_reg & ~clr) | rise;
  assign drop_evt  = |(rise & pend_reg & ~clr);
  assign src       = pend_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_reg     <= '0;
      drop_cnt_reg <= '0;
    end else begin
      pend_reg <= pend_next;
      if (drop_evt && (drop_cnt_reg != {CNT_W{1'b1}})) begin
        drop_cnt_reg <= drop_cnt_reg + 1'b1;
      end
    end
  end

  assign drop_cnt = drop_cnt_reg;
`else
  assign src      = req_q_reg;
  assign drop_cnt = '0;
`endif

  always_comb begin
    state_next     = state_reg;
    irq_valid_next = irq_valid_reg;
    irq_grp_next   = irq_grp_reg;
    irq_ch_next    = irq_ch_reg;
    irq_id_next    = irq_id_reg;
    case (state_reg)
      IDLE: begin
        if (|elig) state_next = ARB;
      end
      ARB: begin
        if (|elig) begin
          irq_valid_next = 1'b1;
          irq_grp_next   = win_grp;
          irq_ch_next    = win_ch;
          irq_id_next    = win_id;
          state_next     = GRANT;
        end else begin
          state_next = IDLE;
        end
      end
      GRANT: begin
        if (irq_ack) begin
          irq_valid_next = 1'b0;
          irq_grp_next   = '0;
          irq_ch_next    = '0;
          irq_id_next    = '0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      req_q_reg       <= '0;
      mask_reg        <= {N{1'b1}};
      any_pending_reg <= 1'b0;
      irq_valid_reg   <= 1'b0;
      irq_grp_reg     <= '0;
      irq_ch_reg      <= '0;
      irq_id_reg      <= '0;
    end else begin
      state_reg       <= state_next;
      req_q_reg       <= req;
      any_pending_reg <= |elig;
      irq_valid_reg   <= irq_valid_next;
      irq_grp_reg     <= irq_grp_next;
      irq_ch_reg      <= irq_ch_next;
      irq_id_reg      <= irq_id_next;
      if (mask_we) mask_reg <= mask_wdata;
    end
  end

  assign mask        = mask_reg;
  assign irq_valid   = irq_valid_reg;
  assign irq_grp     = irq_grp_reg;
  assign irq_ch      = irq_ch_reg;
  assign irq_id      = irq_id_reg;
  assign any_pending = any_pending_reg;

endmodule

// File: tb/tb_irq_prio_ctrl.sv
// Scoreboard bench for irq_prio_ctrl: stimulus queues expected grants, a monitor checks each new grant.
module tb_irq_prio_ctrl;
  localparam int NUM_GRP = 3;
  localparam int GRP_W   = 9;
  localparam int CH_W    = 4;
  localparam int ID_W    = 5;
  localparam int CNT_W   = 8;
  localparam int N       = NUM_GRP * GRP_W;
`ifdef IRQ_EDGE_CAPTURE_EN
  localparam logic EDGE_MODE = 1'b1;
`else
  localparam logic EDGE_MODE = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic [N-1:0]        req;
  logic                mask_we;
  logic [N-1:0]        mask_wdata;
  logic [N-1:0]        mask;
  logic                irq_valid;
  logic [NUM_GRP-1:0]  irq_grp;
  logic [CH_W-1:0]     irq_ch;
  logic [ID_W-1:0]     irq_id;
  logic                irq_ack;
  logic                any_pending;
  logic [CNT_W-1:0]    drop_cnt;

  irq_prio_ctrl #(.NUM_GRP(NUM_GRP), .GRP_W(GRP_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req(req), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .mask(mask), .irq_valid(irq_valid), .irq_grp(irq_grp), .irq_ch(irq_ch),
    .irq_id(irq_id), .irq_ack(irq_ack), .any_pending(any_pending), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [NUM_GRP-1:0] grp;
    logic [CH_W-1:0]    ch;
  } grant_t;

  grant_t exp_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  logic   prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Monitor: every newly presented grant is matched against the next queued expectation.
  always @(negedge clk) begin
    if (irq_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_grant_id", 32'(irq_id), 32'hFFFF_FFFF);
      end else begin
        grant_t e;
        e = exp_q.pop_front();
        check("grant_id",  32'(irq_id),  32'(e.id));
        check("grant_grp", 32'(irq_grp), 32'(e.grp));
        check("grant_ch",  32'(irq_ch),  32'(e.ch));
      end
    end
    prev_valid = irq_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; mask_we = 1'b0; mask_wdata = '0; irq_ack = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic write_mask(input logic [N-1:0] v);
    mask_we = 1'b1; mask_wdata = v;
    step();
    mask_we = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int exp_n);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!irq_valid && n < 20);
    check(name, 32'(n), 32'(exp_n));
  endtask

  task automatic ack_once(input logic [N-1:0] req_after);
    req = req_after; irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
  endtask

  function automatic logic [N-1:0] bitv(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset values, basic grant of channel 13 with 3-edge latency
    do_reset();
    check("rst_valid", 32'(irq_valid), 32'd0);
    check("rst_id", 32'(irq_id), 32'd0);
    check("rst_grp", 32'(irq_grp), 32'd0);
    check("rst_mask", 32'(mask), 32'h07FF_FFFF);
    check("rst_any_pending", 32'(any_pending), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    write_mask('0);
    check("mask_written", 32'(mask), 32'd0);
    exp_q.push_back('{id: 5'd13, grp: 3'b010, ch: 4'd4});
    req = bitv(13);
    wait_valid("t1_latency", 3);
    check("t1_any_pending", 32'(any_pending), 32'd1);
    ack_once('0);
    check("t1_valid_after_ack", 32'(irq_valid), 32'd0);
    step(); step();
    check("t1_any_pending_clear", 32'(any_pending), 32'd0);

    // 2: bits 5 and 20 together, 5 wins, then 20 after ack
    do_reset();
    write_mask('0);
    exp_q.push_back('{id: 5'd5,  grp: 3'b001, ch: 4'd5});
    exp_q.push_back('{id: 5'd20, grp: 3'b100, ch: 4'd2});
    req = bitv(5) | bitv(20);
    wait_valid("t2_first_latency", 3);
    ack_once(bitv(20));
    check("t2_valid_after_ack", 32'(irq_valid), 32'd0);
    wait_valid("t2_regrant_latency", 2);
    ack_once('0);

    // 3: mask bit 5 lands while arbitration is pending, so 20 wins
    do_reset();
    write_mask('0);
    exp_q.push_back('{id: 5'd20, grp: 3'b100, ch: 4'd2});
    req = bitv(5) | bitv(20);
    step();
    mask_we = 1'b1; mask_wdata = 27'h0000020;
    step();
    mask_we = 1'b0;
    check("t3_any_pending_before", 32'(any_pending), 32'd1);
    check("t3_mask", 32'(mask), 32'h0000020);
    wait_valid("t3_latency", 1);
    check("t3_any_pending_after", 32'(any_pending), 32'd1);

    // 4: grant stays frozen while req drops and mask goes all ones
    req = '0;
    write_mask({N{1'b1}});
    for (int i = 0; i < 10; i++) begin
      check("t4_frozen", {20'd0, irq_valid, irq_grp, irq_ch, irq_id},
            {20'd0, 1'b1, 3'b100, 4'd2, 5'd20});
      step();
    end
    ack_once('0);
    check("t4_valid_after_ack", 32'(irq_valid), 32'd0);
    step(); step(); step();
    check("t4_idle_valid", 32'(irq_valid), 32'd0);
    check("t4_any_pending", 32'(any_pending), 32'd0);

    // 5: one-cycle pulses on bit 7, second one arriving before ack
    do_reset();
    write_mask('0);
    if (EDGE_MODE) exp_q.push_back('{id: 5'd7, grp: 3'b001, ch: 4'd7});
    req = bitv(7);
    step();
    req = '0;
    step();
    step();
    check("t5_grant_valid", 32'(irq_valid), 32'(EDGE_MODE));
    req = bitv(7);
    step();
    req = '0;
    step();
    check("t5_drop_cnt", 32'(drop_cnt), 32'(EDGE_MODE));
    ack_once('0);
    check("t5_valid_after_ack", 32'(irq_valid), 32'd0);
    for (int i = 0; i < 6; i++) step();
    check("t5_no_regrant", 32'(irq_valid), 32'd0);
    check("t5_drop_cnt_held", 32'(drop_cnt), 32'(EDGE_MODE));

    // 6: reset during GRANT with a simultaneous ack
    do_reset();
    write_mask('0);
    exp_q.push_back('{id: 5'd3, grp: 3'b001, ch: 4'd3});
    req = bitv(3);
    wait_valid("t6_latency", 3);
    rst = 1'b1; irq_ack = 1'b1;
    step();
    rst = 1'b0; irq_ack = 1'b0;
    check("t6_valid", 32'(irq_valid), 32'd0);
    check("t6_id", 32'(irq_id), 32'd0);
    check("t6_grp", 32'(irq_grp), 32'd0);
    check("t6_mask", 32'(mask), 32'h07FF_FFFF);
    for (int i = 0; i < 4; i++) step();
    check("t6_stays_idle", 32'(irq_valid), 32'd0);
    req = '0;
    step();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/irq_prio_ctrl.md
Name: irq_prio_ctrl

Overview:
- Parametrised, registered priority interrupt controller for BIST-wrapped designs.
- Successor to the fixed 27-channel combinational priority-interrupt benchmark.
- Generalised to NUM_GRP groups of GRP_W channels, with a mask register, a request/acknowledge handshake and an optional sticky edge capture.
- Presents one winning channel at a time to the consumer and holds it stable until acknowledged.

Parameters:
- NUM_GRP, 3: number of priority groups; group 0 has the highest priority.
- GRP_W, 9: channels per group; lower index has higher priority within a group.
- CH_W, $clog2(GRP_W): channel index width.
- ID_W, $clog2(NUM_GRP*GRP_W): flat channel id width.
- CNT_W, 8: drop counter width (edge mode only).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req  in  NUM_GRP*GRP_W  interrupt requests; bit g*GRP_W+c is group g, channel c.
- mask_we  in  1  mask write strobe.
- mask_wdata  in  NUM_GRP*GRP_W  new mask; 1 = channel masked.
- mask  out  NUM_GRP*GRP_W  current mask register.
- irq_valid  out  1  grant valid.
- irq_grp  out  NUM_GRP  one-hot winning group.
- irq_ch  out  CH_W  winning channel within the group.
- irq_id  out  ID_W  irq_grp_index*GRP_W + irq_ch.
- irq_ack  in  1  consumer acknowledge.
- any_pending  out  1  registered OR of (src & ~mask).
- drop_cnt  out  CNT_W  lost-edge counter; reads 0 when the optional feature is off.

Behaviour:
- Reset: clock and reset as fixed above — one clock, clk; reset rst is synchronous and active-high.
- Reset values: mask = all ones; state = IDLE; irq_valid, irq_grp, irq_ch, irq_id, any_pending, drop_cnt = 0.
- Reset asserted in any state, including GRANT, takes effect at that edge; a pending ack is discarded.
- Source vector src:
  - Level mode: src = req_q, the req input registered every cycle.
  - Edge mode: src = sticky pending register.
- Eligibility: elig = src & ~mask, using registered values only.
- Mask write: takes effect at the edge after mask_we; arbitration in that same cycle uses the old mask.
- FSM states: IDLE, ARB, GRANT.
  - IDLE: if |elig, go to ARB; otherwise stay.
  - ARB: recompute elig.
    - If zero (request vanished), return to IDLE with no grant.
    - Otherwise latch the winner into irq_grp/irq_ch/irq_id, set irq_valid=1, go to GRANT.
  - GRANT: outputs frozen regardless of req or mask changes.
    - On irq_ack=1: irq_valid=0 at that edge, return to IDLE.
    - Edge mode: the winner's pending bit clears at the same edge.
- irq_ack outside GRANT is ignored.
- Winner selection: lowest group containing an eligible bit, then lowest channel index within that group.
- Latency:
  - req sampled at edge k.
  - IDLE->ARB at k+1.
  - irq_valid high after k+2.
  - After ack at edge a, the next grant is valid no earlier than a+2.
- Level mode: a still-asserted source is re-granted after ack, with no fairness guarantee.
- any_pending is updated every cycle in all states.

Optional Feature:
- Macro: IRQ_EDGE_CAPTURE_EN.
- Defined:
  - Rising edge of req (req & ~req_q) sets the pending bit.
  - Pending clears only on ack of that bit.
  - Set and clear of the same bit at the same edge: set wins.
  - Edge on an already-pending bit increments drop_cnt, saturating at all ones.
  - drop_cnt clears only on reset.
- Undefined:
  - Pure level mode: no pending register, drop_cnt tied to 0.
  - A one-cycle req pulse can be missed (ARB returns to IDLE).

Test Plan:
1. Reset, mask_wdata=0 via mask_we, hold req bit 13 → after the 3rd edge irq_valid=1, irq_grp=3'b010, irq_ch=4, irq_id=13. Pulse irq_ack → irq_valid=0 next edge.
2. req bits 5 and 20 together, mask=0 → first grant irq_id=5. After ack with req bit 5 dropped (level mode) or cleared (edge mode) → second grant irq_id=20.
3. mask=27'h0000020, req bits 5 and 20 → grant irq_id=20, irq_grp=3'b100, irq_ch=2. any_pending=1 both before and after the write.
4. In GRANT with irq_id=20: drop req, write mask all ones, hold for 10 cycles → irq_valid, irq_id and irq_grp unchanged until ack, then state IDLE and any_pending=0.
5. IRQ_EDGE_CAPTURE_EN: mask=0, one-cycle pulse on bit 7, second pulse before ack → exactly one grant irq_id=7, drop_cnt=1, no regrant after ack. Without the macro → drop_cnt stays 0.
6. Assert rst for one cycle while in GRANT with irq_valid=1 → next cycle irq_valid=0, irq_id=0, mask=all ones, state IDLE; irq_ack asserted during the same cycle has no effect.
